// File: rtl/serial_divider_pkg.sv
// Shared types and helpers for the serial restoring divider.
package serial_divider_pkg;

  // Controller states: waiting for a command, or iterating one quotient bit per clock.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Iteration counter width; it must hold the value DIVIDEND_WIDTH itself.
  function automatic int cnt_width(input int dividend_width);
    return $clog2(dividend_width + 1);
  endfunction

endpackage

// File: rtl/serial_divider_if.sv
// Command/result bundle of the serial divider.
// Optional feature macro: SERIAL_DIVIDER_REMAINDER_EN adds remainder_o.
interface serial_divider_if #(
  parameter int DIVIDEND_WIDTH = 18,
  parameter int DIVISOR_WIDTH  = 11
);

  logic                      divide_cmd_i;
  logic [DIVIDEND_WIDTH-1:0] dividend_i;
  logic [DIVISOR_WIDTH-1:0]  divisor_i;
  logic [DIVIDEND_WIDTH-1:0] quotient_o;
  logic                      busy_o;
  logic                      done_o;
`ifdef SERIAL_DIVIDER_REMAINDER_EN
  logic [DIVISOR_WIDTH-1:0]  remainder_o;
`endif

`ifdef SERIAL_DIVIDER_REMAINDER_EN
  // Requester side: issues commands and operands, observes results.
  modport master (
    output divide_cmd_i, dividend_i, divisor_i,
    input  quotient_o, busy_o, done_o, remainder_o
  );

  // Divider side.
  modport slave (
    input  divide_cmd_i, dividend_i, divisor_i,
    output quotient_o, busy_o, done_o, remainder_o
  );
`else
  // Requester side: issues commands and operands, observes results.
  modport master (
    output divide_cmd_i, dividend_i, divisor_i,
    input  quotient_o, busy_o, done_o
  );

  // Divider side.
  modport slave (
    input  divide_cmd_i, dividend_i, divisor_i,
    output quotient_o, busy_o, done_o
  );
`endif

endinterface

// File: rtl/serial_divider.sv
// Unsigned restoring divider, one quotient bit per clock, single subtractor.
// Latency from accept to done is DIVIDEND_WIDTH+1 cycles; commands while busy
// are dropped. Optional feature macro: SERIAL_DIVIDER_REMAINDER_EN adds the
// remainder output (dividend mod divisor, 0 for a zero divisor).
module serial_divider
  import serial_divider_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = 18,
  parameter int DIVISOR_WIDTH  = 11
) (
  input logic             clk_i,
  input logic             nrst_i,
  serial_divider_if.slave bus
);

  localparam int CNT_W = cnt_width(DIVIDEND_WIDTH);

  state_t                    r_state;
  state_t                    w_next_state;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_done;
  logic [DIVIDEND_WIDTH-1:0] r_quot;

  // Working registers: r_work shifts the dividend out at the top while the
  // quotient bits shift in at the bottom, so after the last iteration it
  // holds the complete quotient.
  logic [DIVIDEND_WIDTH-1:0] r_work;
  logic [DIVISOR_WIDTH-1:0]  r_divisor;
  logic [DIVISOR_WIDTH-1:0]  r_rem;

  logic                      w_accept;
  logic                      w_last;
  logic [DIVISOR_WIDTH:0]    w_trial;
  logic                      w_ge;
  logic [DIVISOR_WIDTH-1:0]  w_rem_next;
  logic [DIVIDEND_WIDTH-1:0] w_work_next;

  assign w_accept = (r_state == IDLE) && bus.divide_cmd_i;
  assign w_last   = (r_state == RUN) && (r_cnt == CNT_W'(1));

  // The stored remainder is always below the divisor, so it fits in
  // DIVISOR_WIDTH bits; the shifted trial value needs one more bit.
  assign w_trial = {r_rem, r_work[DIVIDEND_WIDTH-1]};
  assign w_ge    = (w_trial >= {1'b0, r_divisor});
  // The true difference is below the divisor, so modulo-2^DIVISOR_WIDTH
  // arithmetic yields it exactly.
  assign w_rem_next  = w_ge ? (w_trial[DIVISOR_WIDTH-1:0] - r_divisor)
                            : w_trial[DIVISOR_WIDTH-1:0];
  assign w_work_next = {r_work[DIVIDEND_WIDTH-2:0], w_ge};

  // State register.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  // Next-state logic: accept only when idle, leave RUN after the last bit.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (bus.divide_cmd_i) w_next_state = RUN;
      RUN:     if (w_last)           w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Output logic: busy follows the state, result registers drive the rest.
  always_comb begin
    bus.busy_o     = (r_state == RUN);
    bus.done_o     = r_done;
    bus.quotient_o = r_quot;
  end

  // Control and result registers: iteration counter, done pulse, quotient.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_quot <= '0;
    end else begin
      r_done <= w_last;
      if (w_accept)              r_cnt <= CNT_W'(DIVIDEND_WIDTH);
      else if (r_state == RUN)   r_cnt <= r_cnt - CNT_W'(1);
      if (w_last)                r_quot <= w_work_next;
    end
  end

  // Datapath: load operands at accept, then one restoring step per cycle.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_work    <= bus.dividend_i;
      r_divisor <= bus.divisor_i;
      r_rem     <= '0;
    end else if (r_state == RUN) begin
      r_work <= w_work_next;
      r_rem  <= w_rem_next;
    end
  end

`ifdef SERIAL_DIVIDER_REMAINDER_EN
  logic [DIVISOR_WIDTH-1:0] r_remainder;

  // Remainder result: updates with the quotient, forced to 0 for a zero divisor.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i)     r_remainder <= '0;
    else if (w_last) r_remainder <= (r_divisor == '0) ? '0 : w_rem_next;
  end

  assign bus.remainder_o = r_remainder;
`endif

endmodule

// File: tb/tb_serial_divider.sv
// Self-checking bench for serial_divider: directed vector table, multi-cycle
// corner sequences and a bounded random sweep against a behavioural model.
module tb_serial_divider;
  localparam int DW = 18;
  localparam int VW = 11;
  localparam int LAT = DW + 1;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  serial_divider_if #(.DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(VW)) bus ();

  serial_divider #(.DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(VW)) dut (
    .clk_i  (clk),
    .nrst_i (nrst),
    .bus    (bus)
  );

  typedef struct {
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic [DW-1:0] quot;
    logic [VW-1:0] rem;
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs [NVEC];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive a command with operands at the current (negedge) time.
  task automatic drive_cmd(input logic [DW-1:0] a, input logic [VW-1:0] b);
    bus.divide_cmd_i = 1'b1;
    bus.dividend_i   = a;
    bus.divisor_i    = b;
  endtask

  // From a negedge with a command driven: pass the accept edge, then sample on
  // each following negedge until done_o is seen or the budget expires.
  // done_at is the number of edges after accept at which done is observed.
  task automatic wait_done(input bit hold, output int done_at, output int busy_cnt,
                           output bit q_stable);
    logic [DW-1:0] prev_q;
    prev_q   = bus.quotient_o;
    done_at  = 0;
    busy_cnt = 0;
    q_stable = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 3 * LAT; k++) begin
      @(negedge clk);
      if (bus.busy_o) begin
        busy_cnt++;
        if (bus.quotient_o !== prev_q) q_stable = 1'b0;
      end
      if (k == 1 && !hold) begin
        bus.divide_cmd_i = 1'b0;
        bus.dividend_i   = DW'($urandom);
        bus.divisor_i    = VW'($urandom);
      end
      if (bus.done_o) begin
        done_at = k;
        break;
      end
    end
  endtask

  function automatic logic [DW-1:0] model_q(input logic [DW-1:0] a, input logic [VW-1:0] b);
    if (b == '0) return '1;
    return a / DW'(b);
  endfunction

  function automatic logic [VW-1:0] model_r(input logic [DW-1:0] a, input logic [VW-1:0] b);
    logic [DW-1:0] r;
    if (b == '0) return '0;
    r = a % DW'(b);
    return r[VW-1:0];
  endfunction

  initial begin
    int  done_at;
    int  busy_cnt;
    bit  q_stable;
    bit  seen_done;
    logic [DW-1:0] a;
    logic [VW-1:0] b;

    vecs[0] = '{131072, 1080, 121,    392};
    vecs[1] = '{131072, 2047, 64,     64};
    vecs[2] = '{131072, 1,    131072, 0};
    vecs[3] = '{131072, 1920, 68,     512};
    vecs[4] = '{131072, 0,    262143, 0};
    vecs[5] = '{262143, 2047, 128,    127};
    vecs[6] = '{100,    7,    14,     2};
    vecs[7] = '{0,      5,    0,      0};
    vecs[8] = '{5,      10,   0,      5};
    vecs[9] = '{262143, 1,    262143, 0};

    bus.divide_cmd_i = 1'b0;
    bus.dividend_i   = '0;
    bus.divisor_i    = '0;
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(bus.busy_o), 0);
    check("reset_done", 32'(bus.done_o), 0);
    check("reset_quot", 32'(bus.quotient_o), 0);
`ifdef SERIAL_DIVIDER_REMAINDER_EN
    check("reset_rem", 32'(bus.remainder_o), 0);
`endif
    nrst = 1'b1;
    @(negedge clk);

    // Directed vector table.
    for (int i = 0; i < NVEC; i++) begin
      drive_cmd(vecs[i].dividend, vecs[i].divisor);
      wait_done(1'b0, done_at, busy_cnt, q_stable);
      check($sformatf("vec%0d_quot", i), 32'(bus.quotient_o), 32'(vecs[i].quot));
      check($sformatf("vec%0d_latency", i), 32'(done_at), LAT);
      check($sformatf("vec%0d_busy_cycles", i), 32'(busy_cnt), DW);
      check($sformatf("vec%0d_quot_stable", i), 32'(q_stable), 1);
`ifdef SERIAL_DIVIDER_REMAINDER_EN
      check($sformatf("vec%0d_rem", i), 32'(bus.remainder_o), 32'(vecs[i].rem));
`endif
      @(negedge clk);
      check($sformatf("vec%0d_done_width", i), 32'(bus.done_o), 0);
    end

    // Command during RUN is ignored; first result survives.
    drive_cmd(131072, 1080);
    @(posedge clk);
    @(negedge clk);
    bus.divide_cmd_i = 1'b0;
    repeat (4) @(negedge clk);
    drive_cmd(131072, 1);
    repeat (2) @(negedge clk);
    bus.divide_cmd_i = 1'b0;
    seen_done = 1'b0;
    for (int k = 8; k <= 3 * LAT; k++) begin
      @(negedge clk);
      if (bus.done_o) begin
        done_at   = k;
        seen_done = 1'b1;
        break;
      end
    end
    check("ignore_seen_done", 32'(seen_done), 1);
    check("ignore_latency", 32'(done_at), LAT);
    check("ignore_quot", 32'(bus.quotient_o), 121);
    repeat (2) @(negedge clk);
    check("ignore_no_second_start", 32'(bus.busy_o), 0);

    // Command presented in the done cycle is accepted.
    drive_cmd(262143, 2047);
    wait_done(1'b0, done_at, busy_cnt, q_stable);
    check("b2b_first_quot", 32'(bus.quotient_o), 128);
    drive_cmd(100, 7);
    wait_done(1'b0, done_at, busy_cnt, q_stable);
    check("b2b_second_latency", 32'(done_at), LAT);
    check("b2b_second_quot", 32'(bus.quotient_o), 14);
    check("b2b_second_stable", 32'(q_stable), 1);

    // Level-held command restarts as soon as busy drops.
    @(negedge clk);
    drive_cmd(131072, 2047);
    wait_done(1'b1, done_at, busy_cnt, q_stable);
    check("held_first_latency", 32'(done_at), LAT);
    check("held_first_quot", 32'(bus.quotient_o), 64);
    wait_done(1'b0, done_at, busy_cnt, q_stable);
    check("held_restart_latency", 32'(done_at), LAT);
    check("held_restart_quot", 32'(bus.quotient_o), 64);
    @(negedge clk);

    // Reset mid-division aborts with no done pulse.
    drive_cmd(262143, 3);
    @(posedge clk);
    @(negedge clk);
    bus.divide_cmd_i = 1'b0;
    repeat (8) @(negedge clk);
    nrst = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy_o), 0);
    check("abort_quot", 32'(bus.quotient_o), 0);
    check("abort_done", 32'(bus.done_o), 0);
    @(negedge clk);
    nrst = 1'b1;
    seen_done = 1'b0;
    for (int k = 0; k < 2 * LAT; k++) begin
      @(negedge clk);
      if (bus.done_o || bus.busy_o) seen_done = 1'b1;
    end
    check("abort_no_done", 32'(seen_done), 0);
    drive_cmd(131072, 1080);
    wait_done(1'b0, done_at, busy_cnt, q_stable);
    check("after_abort_latency", 32'(done_at), LAT);
    check("after_abort_quot", 32'(bus.quotient_o), 121);
    @(negedge clk);

    // Random sweep against the model.
    for (int n = 0; n < 1500; n++) begin
      a = DW'($urandom);
      b = (n % 97 == 0) ? '0 : VW'($urandom);
      drive_cmd(a, b);
      wait_done(1'b0, done_at, busy_cnt, q_stable);
      check($sformatf("rand%0d_quot a=%0d b=%0d", n, a, b), 32'(bus.quotient_o), 32'(model_q(a, b)));
      check($sformatf("rand%0d_latency", n), 32'(done_at), LAT);
      check($sformatf("rand%0d_stable", n), 32'(q_stable), 1);
`ifdef SERIAL_DIVIDER_REMAINDER_EN
      check($sformatf("rand%0d_rem", n), 32'(bus.remainder_o), 32'(model_r(a, b)));
`endif
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
